// File: rtl/serial_addsub_ctrl.sv
// Bit-serial adder/subtractor: one full-adder cell reused over WIDTH cycles, LSB first.
// Optional signed-overflow reporting is enabled by defining SERIAL_ADDSUB_OVF_EN.
module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             c_out_o,
  output logic             overflow_o
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             c_out_q;

  logic sum_bit;
  logic carry_nxt;
  logic last_bit;
  logic accept;

  // Single full-adder cell shared by every bit position.
  always_comb begin
    sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
    carry_nxt = (a_q[0] & b_q[0]) | (b_q[0] & carry_q) | (carry_q & a_q[0]);
    last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
    accept    = (state_q == IDLE) && start_i;
  end

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Subtraction is A + ~B + 1: B is inverted at load and the carry FF seeded with sub.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
    end else if (accept) begin
      a_q     <= a_i;
      b_q     <= sub_i ? ~b_i : b_i;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= sub_i;
      c_out_q <= 1'b0;
    end else if (state_q == RUN) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      res_q   <= {sum_bit, res_q[WIDTH-1:1]};
      cnt_q   <= cnt_q + CNT_W'(1);
      carry_q <= carry_nxt;
      if (last_bit) c_out_q <= carry_nxt;
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  // Carry into the MSB; XOR with the carry out gives signed overflow.
  logic msb_cin_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            msb_cin_q <= 1'b0;
    else if (accept)                       msb_cin_q <= 1'b0;
    else if ((state_q == RUN) && last_bit) msb_cin_q <= carry_q;
  end

  assign overflow_o = msb_cin_q ^ c_out_q;
`else
  assign overflow_o = 1'b0;
`endif

  assign busy_o   = (state_q == RUN);
  assign done_o   = (state_q == DONE);
  assign result_o = res_q;
  assign c_out_o  = c_out_q;

endmodule
